// File: rtl/cell_sprite_drawer.sv
// Rasterises one CELL_SIZE x CELL_SIZE board sprite into the VGA adapter write port, one pixel per clock.
// Optional build macro GRID_LINE_EN: ring pixels of empty/disk cells are drawn black as the board grid line.
module cell_sprite_drawer #(
    parameter int CELL_SIZE = 12,
    parameter int CNT_W     = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] x_base,
    input  logic [6:0] y_base,
    input  logic [1:0] select,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       write_en,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] WHITE  = 3'b111;
`ifdef GRID_LINE_EN
    localparam logic [2:0] RING_C = BLACK;
`else
    localparam logic [2:0] RING_C = GREEN;
`endif

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CELL_SIZE - 1);
    localparam logic [CNT_W-1:0] DLO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] DHI  = CNT_W'(CELL_SIZE - 3);

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_row, r_col, w_row, w_col;
    logic [7:0]       r_xb, w_xb;
    logic [6:0]       r_yb, w_yb;
    logic [1:0]       r_sel, w_sel;
    logic [7:0]       r_vga_x, w_vga_x;
    logic [6:0]       r_vga_y, w_vga_y;
    logic [2:0]       r_colour, w_colour;
    logic             r_we, r_busy, r_done;
    logic             w_draw;

    // Disk is the inner square two pixels in from the edge with its four corners clipped.
    function automatic logic [2:0] f_colour(input logic [1:0] sel,
                                            input logic [CNT_W-1:0] row,
                                            input logic [CNT_W-1:0] col);
        logic ring, disk, corner;
        ring   = (row == '0) || (col == '0) || (row == LAST) || (col == LAST);
        disk   = (row >= DLO) && (row <= DHI) && (col >= DLO) && (col <= DHI);
        corner = ((row == DLO) || (row == DHI)) && ((col == DLO) || (col == DHI));
        if (sel == 2'd1)
            return ring ? YELLOW : GREEN;
        if (ring)
            return RING_C;
        if (sel[1] && disk && !corner)
            return sel[0] ? WHITE : BLACK;
        return GREEN;
    endfunction

    always_comb begin
        w_state = r_state;
        w_row   = r_row;
        w_col   = r_col;
        w_xb    = r_xb;
        w_yb    = r_yb;
        w_sel   = r_sel;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state = S_DRAW;
                    w_row   = '0;
                    w_col   = '0;
                    w_xb    = x_base;
                    w_yb    = y_base;
                    w_sel   = select;
                end
            end
            S_DRAW: begin
                if (r_row == LAST && r_col == LAST) begin
                    w_state = S_DONE;
                    w_row   = '0;
                    w_col   = '0;
                end else if (r_col == LAST) begin
                    w_col = '0;
                    w_row = r_row + CNT_W'(1);
                end else begin
                    w_col = r_col + CNT_W'(1);
                end
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase

        // Outputs are precomputed for the pixel that will be on the port after this edge.
        w_draw   = (w_state == S_DRAW);
        w_vga_x  = w_draw ? (w_xb + 8'(w_col)) : r_vga_x;
        w_vga_y  = w_draw ? (w_yb + 7'(w_row)) : r_vga_y;
        w_colour = w_draw ? f_colour(w_sel, w_row, w_col) : r_colour;
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            r_state  <= S_IDLE;
            r_row    <= '0;
            r_col    <= '0;
            r_xb     <= '0;
            r_yb     <= '0;
            r_sel    <= '0;
            r_vga_x  <= '0;
            r_vga_y  <= '0;
            r_colour <= '0;
            r_we     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_row    <= w_row;
            r_col    <= w_col;
            r_xb     <= w_xb;
            r_yb     <= w_yb;
            r_sel    <= w_sel;
            r_vga_x  <= w_vga_x;
            r_vga_y  <= w_vga_y;
            r_colour <= w_colour;
            r_we     <= w_draw;
            r_busy   <= (w_state != S_IDLE);
            r_done   <= (w_state == S_DONE);
        end
    end

    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_colour;
    assign write_en   = r_we;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_cell_sprite_drawer.sv
// Scoreboard bench for cell_sprite_drawer: stimulus pushes expected pixels, a negedge monitor compares writes.
module tb_cell_sprite_drawer;

    localparam int CS = 12;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] WHITE  = 3'b111;
`ifdef GRID_LINE_EN
    localparam logic [2:0] RING_EXP = BLACK;
`else
    localparam logic [2:0] RING_EXP = GREEN;
`endif

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] x_base;
    logic [6:0] y_base;
    logic [1:0] select;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       write_en, busy, done;

    typedef struct {
        int         cyc;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t exp_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [2:0] fb [0:255][0:127];

    cell_sprite_drawer #(.CELL_SIZE(CS), .CNT_W(4)) dut (
        .clock(clock), .resetn(resetn), .start(start),
        .x_base(x_base), .y_base(y_base), .select(select),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .write_en(write_en), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference colour from distance-to-edge geometry.
    function automatic logic [2:0] model_colour(input int sel, input int r, input int c);
        int  d;
        bit  on_ring, clipped;
        d = r;
        if (c < d) d = c;
        if (CS - 1 - r < d) d = CS - 1 - r;
        if (CS - 1 - c < d) d = CS - 1 - c;
        on_ring = (d == 0);
        clipped = ((r == 2) || (r == CS - 3)) && ((c == 2) || (c == CS - 3));
        if (sel == 1) return on_ring ? YELLOW : GREEN;
        if (on_ring) return RING_EXP;
        if (sel >= 2 && d >= 2 && !clipped) return (sel == 3) ? WHITE : BLACK;
        return GREEN;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    always @(negedge clock) begin
        pix_t e;
        int   dc;
        if (write_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: x=%0d y=%0d c=%0d at cycle %0d, expected no write",
                         vga_x, vga_y, vga_colour, cyc);
            end else begin
                e = exp_q.pop_front();
                if (vga_x !== e.x || vga_y !== e.y || vga_colour !== e.c || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pixel: got (%0d,%0d)=%b at cycle %0d, expected (%0d,%0d)=%b at cycle %0d",
                             vga_x, vga_y, vga_colour, cyc, e.x, e.y, e.c, e.cyc);
                end
            end
            fb[vga_x][vga_y] = vga_colour;
        end
        if (done) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: at cycle %0d, expected no done", cyc);
            end else begin
                dc = done_q.pop_front();
                if (cyc != dc || busy !== 1'b1 || write_en !== 1'b0) begin
                    errors++;
                    $display("FAIL done_pulse: cycle %0d busy %0b we %0b, expected cycle %0d busy 1 we 0",
                             cyc, busy, write_en, dc);
                end
            end
        end
    end

    task automatic draw(input int xb, input int yb, input int sel, input bit pert, input int abort_at);
        int T;
        bit finished;
        pix_t p;
        @(negedge clock);
        x_base = 8'(xb);
        y_base = 7'(yb);
        select = 2'(sel);
        start  = 1'b1;
        @(posedge clock);
        #1;
        T = cyc;
        start = 1'b0;
        for (int r = 0; r < CS; r++) begin
            for (int c = 0; c < CS; c++) begin
                p.cyc = T + r * CS + c;
                p.x   = 8'((xb + c) % 256);
                p.y   = 7'((yb + r) % 128);
                p.c   = model_colour(sel, r, c);
                exp_q.push_back(p);
            end
        end
        done_q.push_back(T + CS * CS);
        finished = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (pert) begin
                if (cyc == T + 5) begin
                    x_base = x_base + 8'd77;
                    select = ~select;
                end
                if (cyc == T + 50 || cyc == T + CS * CS) start = 1'b1;
            end
            if (abort_at > 0 && cyc == T + abort_at) begin
                resetn = 1'b1;
                #1;
                chk("abort_write_en", int'(write_en), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_done", int'(done), 0);
                exp_q.delete();
                done_q.delete();
                repeat (2) @(negedge clock);
                resetn = 1'b0;
                finished = 1'b1;
                break;
            end else if (!busy) begin
                chk("busy_release_cycle", cyc, T + CS * CS + 1);
                finished = 1'b1;
                break;
            end
        end
        if (!finished) begin
            errors++;
            checks++;
            $display("FAIL sprite_timeout: busy still %0b after 400 cycles, expected 0", busy);
        end
        chk("leftover_pixels", exp_q.size(), 0);
        chk("leftover_done", done_q.size(), 0);
    endtask

    initial begin
        int wcount;
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 128; j++)
                fb[i][j] = 3'b101;
        resetn = 1'b1;
        start  = 1'b0;
        x_base = '0;
        y_base = '0;
        select = '0;
        repeat (3) @(negedge clock);
        chk("rst_vga_x", int'(vga_x), 0);
        chk("rst_vga_y", int'(vga_y), 0);
        chk("rst_colour", int'(vga_colour), 0);
        chk("rst_write_en", int'(write_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        resetn = 1'b0;
        wcount = 0;
        repeat (10) begin
            @(negedge clock);
            if (write_en) wcount++;
        end
        chk("idle_writes", wcount, 0);

        draw(9, 9, 0, 1'b0, 0);
        chk("t2_14_14", int'(fb[14][14]), int'(GREEN));
        chk("t2_9_9", int'(fb[9][9]), int'(RING_EXP));
        chk("t2_20_20", int'(fb[20][20]), int'(RING_EXP));

        draw(22, 22, 3, 1'b0, 0);
        chk("t3_27_27_white", int'(fb[27][27]), int'(WHITE));
        chk("t3_24_24_clip", int'(fb[24][24]), int'(GREEN));
        chk("t3_24_25_white", int'(fb[24][25]), int'(WHITE));
        draw(22, 22, 2, 1'b0, 0);
        chk("t3_27_27_black", int'(fb[27][27]), int'(BLACK));

        draw(35, 9, 1, 1'b1, 0);
        chk("t4_35_9", int'(fb[35][9]), int'(YELLOW));
        chk("t4_46_20", int'(fb[46][20]), int'(YELLOW));
        chk("t4_40_14", int'(fb[40][14]), int'(GREEN));

        draw(250, 125, 0, 1'b0, 0);
        chk("t5_wrap_0_0", int'(fb[0][0]), int'(GREEN));
        chk("t5_wrap_0_125", int'(fb[0][125]), int'(RING_EXP));
        chk("t5_wrap_255_127", int'(fb[255][127]), int'(GREEN));

        draw(60, 40, 3, 1'b0, 60);
        draw(60, 40, 2, 1'b0, 0);
        chk("t6_65_45_black", int'(fb[65][45]), int'(BLACK));

        for (int n = 0; n < 8; n++)
            draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 3)), n[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
